// File: rtl/s2_struct_packer_if.sv
// Field-stream input and packed s2 word output of the s2 struct packer.
// master is the packer side; slave is the feeding/consuming environment.
interface s2_struct_packer_if;
  logic            fld_valid;
  logic            fld_ready;
  logic [3:0]      fld_data;
  logic            fld_last;
  logic            out_valid;
  logic            out_ready;
  logic [11:0]     out;
  logic [5:0]      out_d;
  logic [1:0][5:0] out_array;

  modport master (
    input  fld_valid, fld_data, fld_last, out_ready,
    output fld_ready, out_valid, out, out_d, out_array
  );

  modport slave (
    output fld_valid, fld_data, fld_last, out_ready,
    input  fld_ready, out_valid, out, out_d, out_array
  );
endinterface

// File: rtl/s2_struct_packer.sv
// Packs a 4-bit field stream (c, d.a, d.b, e) into 12-bit s2 words and
// presents them on a valid/ready port with s1 views and sticky error flags.
module s2_struct_packer #(
  parameter int CNT_W      = 8,
  parameter bit STRICT_PAD = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  s2_struct_packer_if.master bus,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               err_frame,
  output logic               err_pad
);

  typedef enum logic [1:0] {S_C = 2'd0, S_A = 2'd1, S_B = 2'd2, S_E = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [3:0]       c_q, c_d;
  logic [3:0]       a_q, a_d;
  logic [1:0]       b_q, b_d;
  logic [11:0]      word_q, word_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_frame_q, err_frame_d;
  logic             err_pad_q, err_pad_d;
  logic             accept_s;

  function automatic logic pad_bad(input logic [3:0] data);
    return STRICT_PAD && (data[3:2] != 2'b00);
  endfunction

  // A finished word may only enter the output register once the old one is gone.
  assign bus.fld_ready = (state_q != S_E) || !out_valid_q || bus.out_ready;
  assign accept_s      = bus.fld_valid && bus.fld_ready;

  assign bus.out_valid    = out_valid_q;
  assign bus.out          = word_q;
  assign bus.out_d        = word_q[7:2];
  assign bus.out_array[0] = word_q[7:2];
  assign bus.out_array[1] = {word_q[11:8], word_q[1:0]};
  assign word_cnt         = cnt_q;
  assign err_frame        = err_frame_q;
  assign err_pad          = err_pad_q;

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    a_d         = a_q;
    b_d         = b_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    err_frame_d = err_frame_q;
    err_pad_d   = err_pad_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      out_valid_d = out_valid_q;
    end

    if (accept_s) begin
      case (state_q)
        S_C, S_A: begin
          if (bus.fld_last) begin
            err_frame_d = 1'b1;
            state_d     = S_C;
            c_d         = 4'h0;
            a_d         = 4'h0;
            b_d         = 2'b00;
          end else if (state_q == S_C) begin
            c_d     = bus.fld_data;
            state_d = S_A;
          end else begin
            a_d     = bus.fld_data;
            state_d = S_B;
          end
        end
        S_B: begin
          if (pad_bad(bus.fld_data)) begin
            err_pad_d = 1'b1;
          end else begin
            err_pad_d = err_pad_q;
          end
          if (bus.fld_last) begin
            err_frame_d = 1'b1;
            state_d     = S_C;
            c_d         = 4'h0;
            a_d         = 4'h0;
            b_d         = 2'b00;
          end else begin
            b_d     = bus.fld_data[1:0];
            state_d = S_E;
          end
        end
        S_E: begin
          if (pad_bad(bus.fld_data)) begin
            err_pad_d = 1'b1;
          end else begin
            err_pad_d = err_pad_q;
          end
          if (!bus.fld_last) begin
            err_frame_d = 1'b1;
          end else begin
            err_frame_d = err_frame_q;
          end
          word_d      = {c_q, a_q, b_q, bus.fld_data[1:0]};
          out_valid_d = 1'b1;
          state_d     = S_C;
        end
        default: begin
          state_d = S_C;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_C;
      c_q         <= 4'h0;
      a_q         <= 4'h0;
      b_q         <= 2'b00;
      word_q      <= 12'h000;
      out_valid_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      err_frame_q <= 1'b0;
      err_pad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      err_frame_q <= err_frame_d;
      err_pad_q   <= err_pad_d;
    end
  end

endmodule
